// File: rtl/sprite_seq_pkg.sv
// Shared types and helpers for the sprite frame sequencer.
// Holds the FSM state encoding, default sprite geometry and bus slicing helpers.
package sprite_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ERASE,
    ST_LOAD,
    ST_DRAW,
    ST_COMP
  } seq_state_t;

  localparam int DEF_SPR_W   = 5;
  localparam int DEF_SPR_H   = 5;
  localparam int PIX_PER_SPR = DEF_SPR_W * DEF_SPR_H;
  localparam int PIX_CNT_W   = $clog2(PIX_PER_SPR);

  // Width needed to index n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low bit of element idx inside a flattened bus of w-bit elements.
  function automatic int slice_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/sprite_frame_sequencer_if.sv
// Pixel plot bus between the sequencer and the VGA adapter.
interface sprite_frame_sequencer_if #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int COL_W = 3
);
  logic             plot_en;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour;

  modport master (output plot_en, output x, output y, output colour);
  modport slave  (input plot_en, input x, input y, input colour);
endinterface

// File: rtl/pixel_scan_counter.sv
// Raster counter over one SPR_W x SPR_H sprite; wraps to zero after the last pixel.
module pixel_scan_counter
  import sprite_seq_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H,
  localparam int PIX  = SPR_W * SPR_H,
  localparam int CNT_W = idx_width(PIX),
  localparam int CW   = idx_width(SPR_W),
  localparam int RW   = idx_width(SPR_H)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] k,
  output logic [CW-1:0]    col,
  output logic [RW-1:0]    row,
  output logic             last
);

  assign last = (k == CNT_W'(PIX - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k   <= '0;
      col <= '0;
      row <= '0;
    end else if (clr || (en && last)) begin
      k   <= '0;
      col <= '0;
      row <= '0;
    end else if (en) begin
      k <= k + 1'b1;
      if (col == CW'(SPR_W - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_frame_sequencer.sv
// Per-frame erase/redraw sequencer for NUM_SPRITES bitmap sprites with clipping,
// transparency, per-sprite enable and sticky overrun detection.
module sprite_frame_sequencer
  import sprite_seq_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 5,
  parameter int SPR_H       = 5,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COL_W       = 3,
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120,
  parameter int BG_COLOUR   = 0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             go,
  input  logic                             init_req,
  input  logic                             init_done,
  output logic                             init_go,
  input  logic [NUM_SPRITES-1:0]           sprite_en,
  input  logic [NUM_SPRITES*X_W-1:0]       sprite_x,
  input  logic [NUM_SPRITES*Y_W-1:0]       sprite_y,
  input  logic [NUM_SPRITES*COL_W-1:0]     sprite_col,
  input  logic [NUM_SPRITES*SPR_W*SPR_H-1:0] sprite_shape,
  output logic                             load,
  sprite_frame_sequencer_if.master         plot,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overrun
);

  localparam int PIX   = SPR_W * SPR_H;
  localparam int CNT_W = idx_width(PIX);
  localparam int CW    = idx_width(SPR_W);
  localparam int RW    = idx_width(SPR_H);
  localparam int IDX_W = idx_width(NUM_SPRITES);
  localparam logic [X_W:0] X_LIM = (X_W + 1)'(X_MAX);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(Y_MAX);

  seq_state_t state, state_next;

  logic [NUM_SPRITES-1:0]       drawn_valid;
  logic [NUM_SPRITES*X_W-1:0]   snap_x;
  logic [NUM_SPRITES*Y_W-1:0]   snap_y;
  logic [NUM_SPRITES*COL_W-1:0] snap_col;
  logic [NUM_SPRITES*PIX-1:0]   snap_shape;
  logic [IDX_W-1:0]             cur_idx, first_idx, next_idx;
  logic                         has_next;
  logic [NUM_SPRITES-1:0]       search_mask;

  logic             scan_start, cnt_en, sprite_step, in_scan;
  logic [CNT_W-1:0] k;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             scan_last;

  logic [X_W-1:0]   base_x;
  logic [Y_W-1:0]   base_y;
  logic [PIX-1:0]   shape_bits;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;
  logic             visible;
  logic [COL_W-1:0] pix_colour;

  logic             plot_en_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [COL_W-1:0] colour_q;
  logic             overrun_q;

  pixel_scan_counter #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_scan (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (cnt_en),
    .clr     (scan_start),
    .k       (k),
    .col     (col),
    .row     (row),
    .last    (scan_last)
  );

  // LOAD searches the incoming enables since drawn_valid only updates on that edge.
  always_comb begin
    search_mask = (state == ST_LOAD) ? sprite_en : drawn_valid;
    first_idx   = '0;
    next_idx    = '0;
    has_next    = 1'b0;
    for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
      if (search_mask[s]) first_idx = IDX_W'(s);
      if (drawn_valid[s] && (s > int'(cur_idx))) begin
        next_idx = IDX_W'(s);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    scan_start  = 1'b0;
    cnt_en      = 1'b0;
    sprite_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          if (init_req) begin
            state_next = ST_INIT;
          end else if (|drawn_valid) begin
            state_next = ST_ERASE;
            scan_start = 1'b1;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_INIT: begin
        if (init_done) begin
          if (|drawn_valid) begin
            state_next = ST_ERASE;
            scan_start = 1'b1;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_ERASE: begin
        cnt_en = 1'b1;
        if (scan_last) begin
          if (has_next) sprite_step = 1'b1;
          else          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (|sprite_en) begin
          state_next = ST_DRAW;
          scan_start = 1'b1;
        end else begin
          state_next = ST_COMP;
        end
      end
      ST_DRAW: begin
        cnt_en = 1'b1;
        if (scan_last) begin
          if (has_next) sprite_step = 1'b1;
          else          state_next  = ST_COMP;
        end
      end
      ST_COMP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_idx <= '0;
    end else if (scan_start) begin
      cur_idx <= first_idx;
    end else if (sprite_step) begin
      cur_idx <= next_idx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drawn_valid <= '0;
      snap_x      <= '0;
      snap_y      <= '0;
      snap_col    <= '0;
      snap_shape  <= '0;
    end else if (state == ST_LOAD) begin
      drawn_valid <= sprite_en;
      snap_x      <= sprite_x;
      snap_y      <= sprite_y;
      snap_col    <= sprite_col;
      snap_shape  <= sprite_shape;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      overrun_q <= 1'b0;
    else if (go && (state != ST_IDLE)) overrun_q <= 1'b1;
  end

  // The extra sum bit catches coordinate wrap, which must never plot.
  always_comb begin
    in_scan    = (state == ST_ERASE) || (state == ST_DRAW);
    base_x     = snap_x[slice_lsb(int'(cur_idx), X_W) +: X_W];
    base_y     = snap_y[slice_lsb(int'(cur_idx), Y_W) +: Y_W];
    shape_bits = snap_shape[slice_lsb(int'(cur_idx), PIX) +: PIX];
    sum_x      = {1'b0, base_x} + (X_W + 1)'(col);
    sum_y      = {1'b0, base_y} + (Y_W + 1)'(row);
    visible    = shape_bits[k] && (sum_x < X_LIM) && (sum_y < Y_LIM);
    pix_colour = (state == ST_ERASE) ? COL_W'(BG_COLOUR)
                                     : snap_col[slice_lsb(int'(cur_idx), COL_W) +: COL_W];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      plot_en_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
    end else if (in_scan) begin
      plot_en_q <= visible;
      x_q       <= sum_x[X_W-1:0];
      y_q       <= sum_y[Y_W-1:0];
      colour_q  <= pix_colour;
    end else begin
      plot_en_q <= 1'b0;
    end
  end

  assign plot.plot_en = plot_en_q;
  assign plot.x       = x_q;
  assign plot.y       = y_q;
  assign plot.colour  = colour_q;

  assign init_go    = (state == ST_INIT);
  assign load       = (state == ST_LOAD);
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_COMP);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Scoreboard bench: a frame-level model queues every expected visible pixel and
// the frame timing; a monitor pops and compares on each plot strobe.
module tb_sprite_frame_sequencer;

  localparam int NS = 4;
  localparam int SW = 5;
  localparam int SH = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic go = 1'b0, init_req = 1'b0, init_done = 1'b0;
  logic init_go, load, busy, frame_done, overrun;
  logic [NS-1:0]       sprite_en = '0;
  logic [NS*8-1:0]     sprite_x = '0;
  logic [NS*7-1:0]     sprite_y = '0;
  logic [NS*3-1:0]     sprite_col = '0;
  logic [NS*SW*SH-1:0] sprite_shape = '0;

  sprite_frame_sequencer_if #(.X_W(8), .Y_W(7), .COL_W(3)) pif ();

  sprite_frame_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .go           (go),
    .init_req     (init_req),
    .init_done    (init_done),
    .init_go      (init_go),
    .sprite_en    (sprite_en),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_col   (sprite_col),
    .sprite_shape (sprite_shape),
    .load         (load),
    .plot         (pif),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  logic expOverrun = 1'b0;

  // Bank 0 is what the DUT drew last frame, bank 1 is the frame about to be issued.
  logic [NS-1:0]    mEn[2];
  logic [7:0]       mX[2][NS];
  logic [6:0]       mY[2][NS];
  logic [2:0]       mCol[2][NS];
  logic [SW*SH-1:0] mShape[2][NS];

  always @(negedge clock) begin
    if (reset_n && pif.plot_en) begin
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpected_plot got x=%0d y=%0d c=%0d, required no plot",
                 pif.x, pif.y, pif.colour);
      end else begin
        pix_t p;
        p = expQ.pop_front();
        if (pif.x !== p.x || pif.y !== p.y || pif.colour !== p.c) begin
          testsFailed++;
          $display("[TB] FAIL pixel got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                   pif.x, pif.y, pif.colour, p.x, p.y, p.c);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int s = 0; s < NS; s++) begin
      sprite_x[s*8 +: 8]           = mX[1][s];
      sprite_y[s*7 +: 7]           = mY[1][s];
      sprite_col[s*3 +: 3]         = mCol[1][s];
      sprite_shape[s*SW*SH +: SW*SH] = mShape[1][s];
    end
    sprite_en = mEn[1];
  endtask

  task automatic scrambleInputs();
    sprite_en    = NS'($urandom);
    sprite_x     = {$urandom, $urandom};
    sprite_y     = {$urandom};
    sprite_col   = {$urandom};
    sprite_shape = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pushPhase(input int bank, input bit erase);
    for (int s = 0; s < NS; s++) begin
      if (mEn[bank][s]) begin
        for (int r = 0; r < SH; r++) begin
          for (int c = 0; c < SW; c++) begin
            int px, py;
            px = int'(mX[bank][s]) + c;
            py = int'(mY[bank][s]) + r;
            if (mShape[bank][s][r*SW + c] && px < 160 && py < 120) begin
              pix_t p;
              p.x = px[7:0];
              p.y = py[6:0];
              p.c = erase ? 3'd0 : mCol[bank][s];
              expQ.push_back(p);
            end
          end
        end
      end
    end
  endtask

  task automatic setSprite(input int s, input logic en, input int xv, input int yv,
                           input int cv, input logic [SW*SH-1:0] shp);
    mEn[1][s]    = en;
    mX[1][s]     = xv[7:0];
    mY[1][s]     = yv[6:0];
    mCol[1][s]   = cv[2:0];
    mShape[1][s] = shp;
  endtask

  task automatic randomSprites(input bit safe);
    for (int s = 0; s < NS; s++) begin
      if (safe)
        setSprite(s, 1'b1, $urandom_range(0, 150), $urandom_range(0, 110),
                  $urandom_range(0, 7), {SW*SH{1'b1}});
      else
        setSprite(s, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 127),
                  $urandom_range(0, 7), (SW*SH)'($urandom));
    end
  endtask

  task automatic runFrame(input bit withInit, input bit goDuringDraw, input bit resetMid);
    int eCyc, dCyc, iCyc, n, loadN, doneN, initCnt;
    bit aborted;
    eCyc = SW*SH*$countones(mEn[0]);
    dCyc = SW*SH*$countones(mEn[1]);
    iCyc = withInit ? 10 : 0;
    pushPhase(0, 1'b1);
    pushPhase(1, 1'b0);
    applyStimulus();
    @(negedge clock);
    go = 1'b1;
    init_req = withInit;
    n = 0; loadN = -1; doneN = -1; initCnt = 0; aborted = 1'b0;
    while (doneN < 0 && n < 3000 && !aborted) begin
      @(negedge clock);
      n++;
      go = 1'b0;
      init_req = 1'b0;
      if (init_go) begin
        initCnt++;
        init_done = (initCnt == 10);
      end else begin
        init_done = 1'b0;
      end
      if (loadN > 0 && n > loadN) scrambleInputs();
      if (load && loadN < 0) begin
        loadN = n;
        checkOutput("busy_at_load", busy, 1);
      end
      if (goDuringDraw && loadN > 0 && n == loadN + 5) begin
        go = 1'b1;
        expOverrun = 1'b1;
      end
      if (resetMid && loadN > 0 && n == loadN + 10) begin
        reset_n = 1'b0;
        #1;
        checkOutput("reset_plot_en", pif.plot_en, 0);
        checkOutput("reset_xyc", {pif.x, pif.y, pif.colour}, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_overrun", overrun, 0);
        expQ.delete();
        expOverrun = 1'b0;
        mEn[0] = '0;
        aborted = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
      end
      if (frame_done) doneN = n;
    end
    if (!aborted) begin
      if (doneN < 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL frame_timeout got no frame_done, required within 3000 cycles");
      end
      checkOutput("load_cycle", loadN, 1 + iCyc + eCyc);
      checkOutput("done_cycle", doneN, iCyc + eCyc + dCyc + 2);
      if (withInit) checkOutput("init_go_cycles", initCnt, 10);
      @(negedge clock);
      checkOutput("queue_drained", expQ.size(), 0);
      checkOutput("overrun", overrun, expOverrun);
      checkOutput("idle_busy", busy, 0);
      mEn[0] = mEn[1];
      for (int s = 0; s < NS; s++) begin
        mX[0][s] = mX[1][s];
        mY[0][s] = mY[1][s];
        mCol[0][s] = mCol[1][s];
        mShape[0][s] = mShape[1][s];
      end
      expQ.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mEn[0] = '0;
    mEn[1] = '0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rst_plot_en", pif.plot_en, 0);
    checkOutput("rst_outputs", {init_go, load, busy, frame_done, overrun}, 0);
    checkOutput("rst_xyc", {pif.x, pif.y, pif.colour}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    randomSprites(1'b1);
    runFrame(1'b0, 1'b0, 1'b0);
    runFrame(1'b0, 1'b0, 1'b0);

    mEn[1][2] = 1'b0;
    mShape[1][0] = 25'h1FFF;
    runFrame(1'b0, 1'b0, 1'b0);
    runFrame(1'b0, 1'b0, 1'b0);

    setSprite(1, 1'b1, 158, 40, 5, {SW*SH{1'b1}});
    setSprite(3, 1'b1, 20, 118, 6, {SW*SH{1'b1}});
    setSprite(0, 1'b1, 158, 118, 3, {SW*SH{1'b1}});
    runFrame(1'b0, 1'b0, 1'b0);

    randomSprites(1'b1);
    runFrame(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      randomSprites(1'b0);
      runFrame(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    randomSprites(1'b1);
    runFrame(1'b0, 1'b0, 1'b1);
    randomSprites(1'b1);
    runFrame(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
